// File: rtl/nbit_reg_pkg.sv
// Shared helpers for nbit_reg: width limits and the reset-value fit check.
// No logic of its own; constants and a constant function only.
package nbit_reg_pkg;

    localparam int unsigned NBIT_REG_MAX_W = 64;

    // True when value v can be represented in w bits without losing set bits.
    function automatic bit nbit_reg_fits(input logic [63:0] v, input int unsigned w);
        if (w >= 64)
            return 1'b1;
        return (v >> w) == 64'd0;
    endfunction

endpackage

// File: rtl/nbit_reg_bit.sv
// Single storage bit: async active-high reset to rst_val, loads d when en is high.
// Latency: one clk edge from d to q. No backpressure; en simply gates the load.
module nbit_reg_bit (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic en,
    input  logic d,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = en ? d : q_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q_q <= rst_val;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/nbit_reg.sv
// n-bit register loading 'in' when we & gwe, async reset to r; NBIT_REG_BYPASS_EN adds write-through out_byp.
// Latency: one clk edge (out_byp is combinational). No backpressure; gwe acts as a system-wide stall.
module nbit_reg
    import nbit_reg_pkg::*;
#(
    parameter int unsigned n = 1,
    parameter logic [63:0] r = 64'd0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] in,
    input  logic         we,
    input  logic         gwe,
    output logic [n-1:0] out
`ifdef NBIT_REG_BYPASS_EN
    ,
    output logic [n-1:0] out_byp
`endif
);

    // Bad parameterisations stop elaboration instead of silently truncating r.
    if (n < 1 || n > NBIT_REG_MAX_W) begin : g_bad_width
        $error("nbit_reg: n=%0d outside 1..%0d", n, NBIT_REG_MAX_W);
    end
    if (!nbit_reg_fits(r, n)) begin : g_bad_reset
        $error("nbit_reg: reset value r=%h wider than n=%0d bits", r, n);
    end

    localparam logic [n-1:0] R_N = r[n-1:0];

    logic ld;
    assign ld = we & gwe;

    for (genvar i = 0; i < n; i++) begin : g_bit
        nbit_reg_bit u_bit (
            .clk     (clk),
            .rst     (rst),
            .rst_val (R_N[i]),
            .en      (ld),
            .d       (in[i]),
            .q       (out[i])
        );
    end

`ifdef NBIT_REG_BYPASS_EN
    // Reset dominates so consumers never see a write-through while rst is high.
    assign out_byp = rst ? R_N : (ld ? in : out);
`endif

endmodule

// File: tb/tb_nbit_reg.sv
// Self-checking bench for nbit_reg: directed steps followed by randomized traffic against a reference model.
module tb_nbit_reg;

    localparam logic [15:0] R0 = 16'h0000;
    localparam logic [15:0] R1 = 16'hA5A5;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst0, rst1;
    logic [15:0] din;
    logic        we, gwe;
    logic [15:0] out0, out1;
`ifdef NBIT_REG_BYPASS_EN
    logic [15:0] out_byp0, out_byp1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp0, exp1;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    nbit_reg #(.n(16), .r(64'h0000)) u_dut0 (
        .clk     (clk),
        .rst     (rst0),
        .in      (din),
        .we      (we),
        .gwe     (gwe),
        .out     (out0)
`ifdef NBIT_REG_BYPASS_EN
        ,
        .out_byp (out_byp0)
`endif
    );

    nbit_reg #(.n(16), .r(64'hA5A5)) u_dut1 (
        .clk     (clk),
        .rst     (rst1),
        .in      (din),
        .we      (we),
        .gwe     (gwe),
        .out     (out1)
`ifdef NBIT_REG_BYPASS_EN
        ,
        .out_byp (out_byp1)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model: a register is either held at its reset constant, loaded, or unchanged.
    function automatic logic [15:0] next_val(input logic [15:0] cur, input logic [15:0] rv,
                                             input logic rs, input logic [15:0] d,
                                             input logic w, input logic g);
        if (rs) return rv;
        if (w && g) return d;
        return cur;
    endfunction

    task automatic edge_step(input string tag);
        exp0 = next_val(exp0, R0, rst0, din, we, gwe);
        exp1 = next_val(exp1, R1, rst1, din, we, gwe);
        @(posedge clk);
        #1;
        chk({tag, "_out0"}, out0, exp0);
        chk({tag, "_out1"}, out1, exp1);
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0;
        din = 16'h0; we = 1'b0; gwe = 1'b0;
        exp0 = R0; exp1 = R1;

        // Async reset with the clock stopped.
        #2;
        rst0 = 1'b1; rst1 = 1'b1;
        #1;
        chk("rst_noclk0", out0, R0);
        chk("rst_noclk1", out1, R1);

        clk_run = 1'b1;
        din = 16'hBEEF; we = 1'b1; gwe = 1'b1;
        for (int i = 0; i < 3; i++) edge_step("rst_hold");

        // Load then hold.
        rst0 = 1'b0; rst1 = 1'b0;
        din = 16'h1234;
        edge_step("load");
        chk("load_val", out0, 16'h1234);
        din = 16'h5678; we = 1'b0;
        edge_step("we_hold");
        chk("we_hold_val", out0, 16'h1234);

        // Global gate.
        we = 1'b1; gwe = 1'b0; din = 16'hFFFF;
        for (int i = 0; i < 4; i++) edge_step("gwe_hold");
        chk("gwe_hold_val", out0, 16'h1234);
        gwe = 1'b1;
        edge_step("gwe_load");
        chk("gwe_load_val", out0, 16'hFFFF);

        // Mid-cycle reset pulse on the A5A5 instance.
        we = 1'b0;
        #2;
        rst1 = 1'b1;
        #1;
        chk("mid_rst1", out1, R1);
        chk("mid_rst_other", out0, 16'hFFFF);
        exp1 = R1;
        rst1 = 1'b0;
        edge_step("post_pulse");

        // Reset priority over a load, then release between edges.
        rst0 = 1'b1; rst1 = 1'b1;
        din = 16'h00FF; we = 1'b1; gwe = 1'b1;
        edge_step("rst_prio");
        #2;
        rst0 = 1'b0; rst1 = 1'b0;
        #1;
        chk("rel_still_r0", out0, R0);
        chk("rel_still_r1", out1, R1);
        edge_step("rel_load");
        chk("rel_load_val", out1, 16'h00FF);

`ifdef NBIT_REG_BYPASS_EN
        din = 16'h1111;
        edge_step("byp_pre");
        din = 16'h2222;
        #1;
        chk("byp_thru", out_byp0, 16'h2222);
        chk("byp_old", out0, 16'h1111);
        edge_step("byp_load");
        chk("byp_after", out0, 16'h2222);
        we = 1'b0; din = 16'h3333;
        #1;
        chk("byp_hold", out_byp0, 16'h2222);
        rst1 = 1'b1; we = 1'b1;
        #1;
        chk("byp_rst", out_byp1, R1);
        exp1 = R1;
        rst1 = 1'b0;
        edge_step("byp_rel");
`endif

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            din  = 16'($urandom);
            we   = 1'($urandom_range(0, 1));
            gwe  = 1'($urandom_range(0, 3) != 0);
            rst0 = ($urandom_range(0, 15) == 0);
            rst1 = ($urandom_range(0, 15) == 0);
`ifdef NBIT_REG_BYPASS_EN
            #1;
            chk("rnd_byp0", out_byp0, rst0 ? R0 : ((we && gwe) ? din : exp0));
            chk("rnd_byp1", out_byp1, rst1 ? R1 : ((we && gwe) ? din : exp1));
`endif
            edge_step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
